// File: rtl/prog_pla_seq_if.sv
// Configuration port of the programmable PLA: row writes plus a commit
// strobe, with ready/error status returned by the PLA.
interface prog_pla_seq_if #(
    parameter int AW    = 4,
    parameter int CFG_W = 10
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [AW-1:0]    cfg_addr;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_commit;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, cfg_commit,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/prog_pla_seq.sv
// Field-programmable PLA with double-buffered AND/OR planes and per-output
// macrocell registers fed back into the AND plane. Rows 0..N_TERM-1 are
// AND-plane literal masks; rows N_TERM..N_ROW-1 hold an OR-plane term mask,
// a registered-output select and an output invert.
module prog_pla_seq #(
    parameter int N_IN   = 3,
    parameter int N_TERM = 8,
    parameter int N_OUT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   in,
    input  logic              en,
    output logic [N_OUT-1:0]  out,
    prog_pla_seq_if.slave     cfg
);
    localparam int N_SIG = N_IN + N_OUT;
    localparam int N_LIT = 2 * N_SIG;
    localparam int CFG_W = (N_LIT > N_TERM + 2) ? N_LIT : N_TERM + 2;
    localparam int N_ROW = N_TERM + N_OUT;
    localparam int AW    = $clog2(N_ROW);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    logic [CFG_W-1:0] shadow [N_ROW];
    logic [CFG_W-1:0] active [N_ROW];

    state_t            state_q, state_d;
    logic              ready;
    logic              wr_fire;
    logic              do_commit;
    logic              addr_ok;
    logic              err_q;
    logic [N_OUT-1:0]  q;
    logic [N_OUT-1:0]  f;
    logic [N_OUT-1:0]  reg_en;
    logic [N_TERM-1:0] term;
    logic [N_SIG-1:0]  s;

    // Feedback registers sit above the primary inputs in the literal space.
    assign s       = {q, in};
    assign addr_ok = ({1'b0, cfg.cfg_addr} < (AW+1)'(N_ROW));

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = err_q;

    // Config FSM: accept writes in RUN, spend exactly one cycle in COMMIT.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        ready     = 1'b0;
        wr_fire   = 1'b0;
        do_commit = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                ready   = 1'b1;
                wr_fire = cfg.cfg_valid;
                if (cfg.cfg_commit) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                do_commit = 1'b1;
                state_d   = ST_RUN;
            end
        endcase
    end

    // Config state, shadow writes, shadow->active copy and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            err_q   <= 1'b0;
            // NOTE: both planes are cleared on reset so an unprogrammed PLA
            // drives zeros and a half-loaded shadow never survives a reset.
            for (int r = 0; r < N_ROW; r++) begin
                shadow[r] <= '0;
                active[r] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register here samples pre-edge values; the commit copy below
            // therefore sees the shadow as written in the previous cycle.
            state_q <= state_d;
            err_q   <= wr_fire && !addr_ok;
            if (wr_fire && addr_ok) shadow[cfg.cfg_addr] <= cfg.cfg_data;
            if (do_commit) begin
                for (int r = 0; r < N_ROW; r++) active[r] <= shadow[r];
            end
        end
    end

    // AND plane: a term is the AND of its selected literals; an empty mask is 0.
    always_comb begin
        logic [N_LIT-1:0] mask;
        logic             hit;
        term = '0;
        for (int t = 0; t < N_TERM; t++) begin
            mask = active[t][N_LIT-1:0];
            hit  = |mask;
            for (int k = 0; k < N_SIG; k++) begin
                if (mask[2*k]   && !s[k]) hit = 1'b0;
                if (mask[2*k+1] &&  s[k]) hit = 1'b0;
            end
            term[t] = hit;
        end
    end

    // OR plane, optional inversion and registered/combinational output select.
    always_comb begin
        f      = '0;
        reg_en = '0;
        out    = '0;
        for (int o = 0; o < N_OUT; o++) begin
            f[o]      = (|(active[N_TERM+o][N_TERM-1:0] & term))
                        ^ active[N_TERM+o][N_TERM+1];
            reg_en[o] = active[N_TERM+o][N_TERM];
            out[o]    = reg_en[o] ? q[o] : f[o];
        end
    end

    // Macrocell registers load the OR-plane result on every enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (en) q <= f;
    end
endmodule

// File: tb/tb_prog_pla_seq.sv
// Directed bench for prog_pla_seq: XOR logic, shadow isolation, a 2-bit
// feedback counter, bad addresses, write+commit overlap and reset mid-commit.
module tb_prog_pla_seq;
    logic       clk;
    logic       rst_n;
    logic [2:0] pin;
    logic       en;
    logic [1:0] pout;

    int n_checks = 0;
    int n_fail   = 0;

    prog_pla_seq_if #(.AW(4), .CFG_W(10)) cfg_if ();

    prog_pla_seq #(.N_IN(3), .N_TERM(8), .N_OUT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (pin),
        .en    (en),
        .out   (pout),
        .cfg   (cfg_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [9:0] d, input logic c);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_addr   = a;
        cfg_if.cfg_data   = d;
        cfg_if.cfg_commit = c;
        tick();
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_commit = 1'b0;
    endtask

    task automatic commit_pulse();
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_commit = 1'b0;
        tick();
    endtask

    initial begin
        logic [1:0] cnt_exp [4];
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0};

        rst_n             = 1'b0;
        pin               = 3'b000;
        en                = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_addr   = '0;
        cfg_if.cfg_data   = '0;
        cfg_if.cfg_commit = 1'b0;

        // Reset state
        #12;
        check("rst_out",   pout,             2'b00);
        check("rst_ready", cfg_if.cfg_ready, 1'b1);
        check("rst_err",   cfg_if.cfg_err,   1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // XOR: two cross terms ORed into out[0], combinational
        cfg_wr(4'd0, 10'b0000000110, 1'b0);
        cfg_wr(4'd1, 10'b0000001001, 1'b0);
        cfg_wr(4'd8, 10'b0000000011, 1'b0);
        pin = 3'b001;
        #1;
        check("xor_precommit", pout, 2'b00);
        commit_pulse();
        for (int i = 0; i < 8; i++) begin
            pin = 3'(i);
            #1;
            check("xor_sweep", pout, {1'b0, pin[0] ^ pin[1]});
        end

        // Shadow isolation: invert-only row8 not visible until commit
        cfg_wr(4'd8, 10'b1000000000, 1'b0);
        pin = 3'b001;
        #1;
        check("iso_hold_a", pout, 2'b01);
        pin = 3'b011;
        #1;
        check("iso_hold_b", pout, 2'b00);
        commit_pulse();
        pin = 3'b000;
        #1;
        check("iso_commit_a", pout, 2'b01);
        pin = 3'b011;
        #1;
        check("iso_commit_b", pout, 2'b01);

        // 2-bit counter through macrocell feedback
        pin = 3'b000;
        cfg_wr(4'd0, 10'b0010000000, 1'b0);
        cfg_wr(4'd1, 10'b0110000000, 1'b0);
        cfg_wr(4'd2, 10'b1001000000, 1'b0);
        cfg_wr(4'd8, 10'b0100000001, 1'b0);
        cfg_wr(4'd9, 10'b0100000110, 1'b0);
        commit_pulse();
        check("cnt_start", pout, 2'b00);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cnt_step", pout, cnt_exp[i]);
        end
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cnt_hold", pout, 2'b01);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        check("cnt_resume", pout, 2'b10);

        // Bad address: dropped, one-cycle error pulse, port stays ready
        cfg_wr(4'd12, 10'h3FF, 1'b0);
        check("bad_err_hi", cfg_if.cfg_err,   1'b1);
        check("bad_ready",  cfg_if.cfg_ready, 1'b1);
        tick();
        check("bad_err_lo", cfg_if.cfg_err,   1'b0);
        commit_pulse();
        check("bad_no_write", pout, 2'b10);

        // Write and commit in the same cycle; a write during COMMIT is ignored
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_addr   = 4'd8;
        cfg_if.cfg_data   = 10'b1000000000;
        cfg_if.cfg_commit = 1'b1;
        tick();
        check("wc_ready_lo", cfg_if.cfg_ready, 1'b0);
        check("wc_old_cfg",  pout,             2'b10);
        cfg_if.cfg_addr   = 4'd9;
        cfg_if.cfg_data   = 10'b0000000000;
        tick();
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_commit = 1'b0;
        check("wc_ready_hi", cfg_if.cfg_ready, 1'b1);
        check("wc_new_cfg",  pout,             2'b11);
        commit_pulse();
        check("wc_commit_write_dropped", pout, 2'b11);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("wc_q_eleven", pout, 2'b11);

        // Reset during COMMIT with a partly reloaded shadow
        cfg_wr(4'd9, 10'b1000000000, 1'b0);
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_commit = 1'b0;
        check("rc_in_commit", cfg_if.cfg_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rc_out",   pout,             2'b00);
        check("rc_ready", cfg_if.cfg_ready, 1'b1);
        check("rc_err",   cfg_if.cfg_err,   1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        commit_pulse();
        pin = 3'b111;
        #1;
        check("rc_empty_a", pout, 2'b00);
        pin = 3'b000;
        #1;
        check("rc_empty_b", pout, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
